pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle control FSM that sequences the 10-bit program counter of the RAT CPU. It drives ProgramCounter's load, increment and reset controls, the PC input-mux select, and the stack/scratch-RAM controls needed for branch, call, return and interrupt flow. It covers control-flow instructions only; ALU and register-file control is handled elsewhere. It sits between the instruction register/flag registers and the ProgramCounter, stack pointer and scratch RAM.

## Interface
Parameters:
- none. Opcode and mux-select encodings come from the package.

Ports (clock and reset first):
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- OPCODE  in  7  instruction bits [17:11]. Stable from FETCH through EXEC.
- C_FLAG, Z_FLAG  in  1 each  current carry and zero flags.
- INT  in  1  interrupt request, level, synchronous to CLK.
- PC_RST  out  1  reset to ProgramCounter.
- PC_LD, PC_INC  out  1 each  ProgramCounter load and increment.
- PC_MUX_SEL  out  2  PC input select: 00 = immediate from instruction, 01 = scratch-RAM data (return), 10 = vector 0x3FF.
- SP_INCR, SP_DECR  out  1 each  stack pointer control.
- SCR_WE  out  1  scratch RAM write enable.
- SCR_ADDR_SEL  out  2  scratch address select: 10 = SP, 11 = SP−1.
- SCR_DATA_SEL  out  1  scratch write data select: 1 = PC_COUNT.
- FLG_SAVE, FLG_RESTORE  out  1 each  copy flags to the shadow register, or copy the shadow back to the flags.
- I_EN  out  1  interrupt-enable register (observation only).

## Operation
- States: INIT, FETCH, EXEC, INTR.
- INIT: PC_RST=1. Next state is FETCH.
- FETCH: PC_INC=1. Next state is EXEC.
- EXEC decodes OPCODE:
  - BRN 0010000: PC_LD, SEL=00.
  - CALL 0010001: PC_LD, SEL=00, SCR_WE, ADDR_SEL=11, DATA_SEL=1, SP_DECR.
  - BREQ 0010010: PC_LD, SEL=00, gated by Z_FLAG=1.
  - BRNE 0010011: gated by Z_FLAG=0.
  - BRCS 0010100: gated by C_FLAG=1.
  - BRCC 0010101: gated by C_FLAG=0.
  - RET 0110010: PC_LD, SEL=01, ADDR_SEL=10, SP_INCR.
  - RETID 0110110 and RETIE 0110111: same as RET plus FLG_RESTORE. I_EN is cleared by RETID and set by RETIE.
  - SEI 0110100: sets I_EN.
  - CLI 0110101: clears I_EN.
  - Any other opcode: no PC or stack action.
- EXEC exit: go to INTR if int_pend && I_EN after this instruction's I_EN update. Otherwise go to FETCH.
- INTR: PC_LD, SEL=10, SCR_WE, ADDR_SEL=11, DATA_SEL=1, SP_DECR, FLG_SAVE. I_EN is cleared. Next state is FETCH.
- int_pend:
  - Set on any cycle where INT=1.
  - Cleared on the cycle INTR is entered.
  - Also cleared by RST.
  - An INT that arrives while I_EN=0 stays pending until an SEI or RETIE.
- Every output not listed for a state is 0. All outputs are decoded from state, OPCODE and flags only.

## Timing
- Instruction latency: 2 cycles (FETCH, EXEC). An interrupt adds 1 cycle (INTR).
- PC_INC in FETCH means PC_COUNT already holds the return address in EXEC and INTR. CALL and INTR push that value.
- Scratch RAM read is asynchronous, so RET loads PC in the same EXEC cycle.
- Reset values:
  - state = INIT, I_EN = 0, int_pend = 0.
  - While RST is high and for the first cycle after release: PC_RST=1 and all other outputs are 0.
- RST asserted mid-EXEC or mid-INTR: outputs drop to the INIT values immediately (asynchronously). No partial push is committed after the edge.
- Simultaneous events:
  - INT during a CALL EXEC: CALL completes, then INTR runs next cycle. This gives two pushes, SP decremented twice.
  - SEI in EXEC with INT pending: INTR is taken directly after that EXEC.
  - CLI in EXEC with INT pending: no INTR; the interrupt stays pending.

## Structure
- Package rat_ctrl_pkg holds:
  - the opcode enum (7-bit values above),
  - the state enum,
  - PC_MUX_SEL and SCR_ADDR_SEL localparams,
  - the vector constant 10'h3FF.
- One sub-module, int_ctrl, holds int_pend, the I_EN register and the interrupt-take decision.
- The FSM and output decode live in pc_sequencer.

## Test plan
- Reset: RST=1 for 2 cycles, then release. Expect PC_RST=1 through the first post-reset cycle, then FETCH with PC_INC=1 and I_EN=0.
- Conditional branch: BREQ with Z=1 → PC_LD=1, SEL=00 in EXEC. BREQ with Z=0 → PC_LD=0. Repeat for BRNE, BRCS, BRCC.
- Call and return: CALL → EXEC shows SCR_WE=1, ADDR_SEL=11, SP_DECR=1, PC_LD=1. RET → SEL=01, ADDR_SEL=10, SP_INCR=1.
- Interrupt gating: INT pulse while I_EN=0 → no INTR. Then SEI → INTR follows that EXEC, with SEL=10, FLG_SAVE=1, I_EN→0.
- RETIE: in EXEC, FLG_RESTORE=1 and SEL=01; I_EN=1 afterwards. RETID: same, but I_EN=0 afterwards.
- Reset mid-INTR: assert RST during the INTR cycle → SCR_WE and PC_LD drop to 0 within the same cycle, state returns to INIT, and int_pend is cleared.

Source files
------------

// File: rtl/rat_ctrl_pkg.sv
// Shared encodings for the RAT CPU control-flow sequencer.
// Holds the opcode and state enums, the PC input-mux and scratch-address
// select codes, the interrupt vector, and the I_EN update helper.
package rat_ctrl_pkg;

  typedef enum logic [6:0] {
    OP_BRN   = 7'b0010000,
    OP_CALL  = 7'b0010001,
    OP_BREQ  = 7'b0010010,
    OP_BRNE  = 7'b0010011,
    OP_BRCS  = 7'b0010100,
    OP_BRCC  = 7'b0010101,
    OP_RET   = 7'b0110010,
    OP_SEI   = 7'b0110100,
    OP_CLI   = 7'b0110101,
    OP_RETID = 7'b0110110,
    OP_RETIE = 7'b0110111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_INTR  = 2'd3
  } state_e;

  localparam logic [1:0] PC_SEL_IMM = 2'b00;  // immediate from instruction
  localparam logic [1:0] PC_SEL_STK = 2'b01;  // scratch-RAM data (return)
  localparam logic [1:0] PC_SEL_VEC = 2'b10;  // interrupt vector

  localparam logic [1:0] SCR_ADDR_SP    = 2'b10;
  localparam logic [1:0] SCR_ADDR_SP_M1 = 2'b11;

  localparam logic [9:0] INT_VECTOR = 10'h3FF;

  // I_EN value that results from executing an opcode.
  function automatic logic ien_after(input logic [6:0] op, input logic ien);
    case (opcode_e'(op))
      OP_SEI, OP_RETIE: ien_after = 1'b1;
      OP_CLI, OP_RETID: ien_after = 1'b0;
      default:          ien_after = ien;
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the sequencer and the datapath it steers.
// Inputs to the sequencer: OPCODE, C_FLAG, Z_FLAG, INT.
// Outputs from the sequencer: PC controls, PC mux select, stack pointer and
// scratch-RAM controls, flag save/restore, and I_EN for observation.
// master = sequencer side, slave = datapath side.
interface pc_sequencer_if;
  logic [6:0] OPCODE;
  logic       C_FLAG;
  logic       Z_FLAG;
  logic       INT;
  logic       PC_RST;
  logic       PC_LD;
  logic       PC_INC;
  logic [1:0] PC_MUX_SEL;
  logic       SP_INCR;
  logic       SP_DECR;
  logic       SCR_WE;
  logic [1:0] SCR_ADDR_SEL;
  logic       SCR_DATA_SEL;
  logic       FLG_SAVE;
  logic       FLG_RESTORE;
  logic       I_EN;

  modport master (
    input  OPCODE, C_FLAG, Z_FLAG, INT,
    output PC_RST, PC_LD, PC_INC, PC_MUX_SEL, SP_INCR, SP_DECR, SCR_WE,
           SCR_ADDR_SEL, SCR_DATA_SEL, FLG_SAVE, FLG_RESTORE, I_EN
  );

  modport slave (
    output OPCODE, C_FLAG, Z_FLAG, INT,
    input  PC_RST, PC_LD, PC_INC, PC_MUX_SEL, SP_INCR, SP_DECR, SCR_WE,
           SCR_ADDR_SEL, SCR_DATA_SEL, FLG_SAVE, FLG_RESTORE, I_EN
  );
endinterface

// File: rtl/pc_sequencer_int_ctrl.sv
// Interrupt bookkeeping for the sequencer: pending latch, I_EN register and
// the decision to enter INTR after the current EXEC.
// Ports: clk_i, rst_i (async, active-high), int_i (level request),
// exec_i / intr_i (sequencer is in EXEC / INTR), opcode_i (instruction in
// EXEC), i_en_o (enable register), take_o (go to INTR at the next edge).
module int_ctrl
  import rat_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       int_i,
  input  logic       exec_i,
  input  logic       intr_i,
  input  logic [6:0] opcode_i,
  output logic       i_en_o,
  output logic       take_o
);

  logic pend_q, pend_d;
  logic ien_q, ien_d;
  logic ien_exec;

  always_comb begin
    // Enable as it stands once this EXEC's SEI/CLI/RETI* has taken effect,
    // so SEI with a pending request goes straight to INTR and CLI blocks it.
    ien_exec = exec_i ? ien_after(opcode_i, ien_q) : ien_q;
    // A request arriving during EXEC itself is also honoured.
    take_o   = exec_i && (pend_q || int_i) && ien_exec;
    ien_d    = intr_i ? 1'b0 : ien_exec;
    pend_d   = take_o ? 1'b0 : (pend_q || int_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= 1'b0;
      ien_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ien_q  <= ien_d;
    end
  end

  assign i_en_o = ien_q;

endmodule

// File: rtl/pc_sequencer.sv
// Control-flow sequencer for the RAT CPU program counter.
// INIT -> FETCH -> EXEC -> (INTR ->) FETCH ...
// Ports: CLK, RST (async, active-high), bus (pc_sequencer_if.master) carrying
// OPCODE/flags/INT in and PC, stack, scratch-RAM and flag controls out.
// Outputs are decoded combinationally from state, OPCODE and flags, so an
// asynchronous reset drops them to INIT values without waiting for an edge.
module pc_sequencer
  import rat_ctrl_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  pc_sequencer_if.master bus
);

  state_e state_q, state_d;
  logic   take;
  logic   ien;

  int_ctrl u_int_ctrl (
    .clk_i    (CLK),
    .rst_i    (RST),
    .int_i    (bus.INT),
    .exec_i   (state_q == ST_EXEC),
    .intr_i   (state_q == ST_INTR),
    .opcode_i (bus.OPCODE),
    .i_en_o   (ien),
    .take_o   (take)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  logic       pc_rst, pc_ld, pc_inc, sp_incr, sp_decr, scr_we;
  logic       scr_data_sel, flg_save, flg_restore;
  logic [1:0] pc_mux_sel, scr_addr_sel;

  always_comb begin
    state_d      = state_q;
    pc_rst       = 1'b0;
    pc_ld        = 1'b0;
    pc_inc       = 1'b0;
    pc_mux_sel   = PC_SEL_IMM;
    sp_incr      = 1'b0;
    sp_decr      = 1'b0;
    scr_we       = 1'b0;
    scr_addr_sel = 2'b00;
    scr_data_sel = 1'b0;
    flg_save     = 1'b0;
    flg_restore  = 1'b0;
    case (state_q)
      ST_INIT: begin
        pc_rst  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        pc_inc  = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = take ? ST_INTR : ST_FETCH;
        case (opcode_e'(bus.OPCODE))
          OP_BRN:  pc_ld = 1'b1;
          OP_BREQ: pc_ld = bus.Z_FLAG;
          OP_BRNE: pc_ld = ~bus.Z_FLAG;
          OP_BRCS: pc_ld = bus.C_FLAG;
          OP_BRCC: pc_ld = ~bus.C_FLAG;
          OP_CALL: begin
            // PC_COUNT already holds the return address after FETCH.
            pc_ld        = 1'b1;
            scr_we       = 1'b1;
            scr_addr_sel = SCR_ADDR_SP_M1;
            scr_data_sel = 1'b1;
            sp_decr      = 1'b1;
          end
          OP_RET, OP_RETID, OP_RETIE: begin
            // Scratch read is asynchronous, so the pop lands this cycle.
            pc_ld        = 1'b1;
            pc_mux_sel   = PC_SEL_STK;
            scr_addr_sel = SCR_ADDR_SP;
            sp_incr      = 1'b1;
            flg_restore  = (bus.OPCODE != OP_RET);
          end
          default: ;
        endcase
      end
      ST_INTR: begin
        pc_ld        = 1'b1;
        pc_mux_sel   = PC_SEL_VEC;
        scr_we       = 1'b1;
        scr_addr_sel = SCR_ADDR_SP_M1;
        scr_data_sel = 1'b1;
        sp_decr      = 1'b1;
        flg_save     = 1'b1;
        state_d      = ST_FETCH;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.PC_RST       = pc_rst;
  assign bus.PC_LD        = pc_ld;
  assign bus.PC_INC       = pc_inc;
  assign bus.PC_MUX_SEL   = pc_mux_sel;
  assign bus.SP_INCR      = sp_incr;
  assign bus.SP_DECR      = sp_decr;
  assign bus.SCR_WE       = scr_we;
  assign bus.SCR_ADDR_SEL = scr_addr_sel;
  assign bus.SCR_DATA_SEL = scr_data_sel;
  assign bus.FLG_SAVE     = flg_save;
  assign bus.FLG_RESTORE  = flg_restore;
  assign bus.I_EN         = ien;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes the hand-computed
// output vector for every cycle it drives; the monitor pops and compares at
// the falling edge.
module tb_pc_sequencer;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pc_sequencer_if bus ();
  pc_sequencer dut (.CLK(CLK), .RST(RST), .bus(bus));

  // Expected vector layout (13 bits, I_EN appended as LSB when compared):
  // rst ld inc sel[2] spi spd we asel[2] dsel fs fr
  localparam logic [12:0] E_INIT = 13'b1_0_0_00_0_0_0_00_0_0_0;
  localparam logic [12:0] E_FTCH = 13'b0_0_1_00_0_0_0_00_0_0_0;
  localparam logic [12:0] E_NONE = 13'b0_0_0_00_0_0_0_00_0_0_0;
  localparam logic [12:0] E_BR   = 13'b0_1_0_00_0_0_0_00_0_0_0;
  localparam logic [12:0] E_CALL = 13'b0_1_0_00_0_1_1_11_1_0_0;
  localparam logic [12:0] E_RET  = 13'b0_1_0_01_1_0_0_10_0_0_0;
  localparam logic [12:0] E_RETI = 13'b0_1_0_01_1_0_0_10_0_0_1;
  localparam logic [12:0] E_INTR = 13'b0_1_0_10_0_1_1_11_1_1_0;

  localparam logic [6:0] BRN = 7'b0010000, CALL = 7'b0010001, BREQ = 7'b0010010,
    BRNE = 7'b0010011, BRCS = 7'b0010100, BRCC = 7'b0010101, RET = 7'b0110010,
    SEI = 7'b0110100, CLI = 7'b0110101, RETID = 7'b0110110, RETIE = 7'b0110111,
    NOP = 7'b1000010;

  typedef struct {
    logic [13:0] v;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Monitor
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      logic [13:0] act;
      e   = exp_q.pop_front();
      act = {bus.PC_RST, bus.PC_LD, bus.PC_INC, bus.PC_MUX_SEL, bus.SP_INCR,
             bus.SP_DECR, bus.SCR_WE, bus.SCR_ADDR_SEL, bus.SCR_DATA_SEL,
             bus.FLG_SAVE, bus.FLG_RESTORE, bus.I_EN};
      n_chk++;
      if (act !== e.v) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
      end
    end
  end

  task automatic cyc(input logic rst, input logic [6:0] op, input logic c,
                     input logic z, input logic irq, input logic [12:0] e,
                     input logic ien, input string nm);
    exp_t x;
    @(posedge CLK);
    #1;
    RST        = rst;
    bus.OPCODE = op;
    bus.C_FLAG = c;
    bus.Z_FLAG = z;
    bus.INT    = irq;
    x.v  = {e, ien};
    x.nm = nm;
    exp_q.push_back(x);
  endtask

  // FETCH then EXEC of one instruction; ien is I_EN during both cycles.
  task automatic instr(input logic [6:0] op, input logic c, input logic z,
                       input logic irq_f, input logic irq_e,
                       input logic [12:0] e, input logic ien, input string nm);
    cyc(1'b0, op, c, z, irq_f, E_FTCH, ien, {nm, ".fetch"});
    cyc(1'b0, op, c, z, irq_e, e, ien, {nm, ".exec"});
  endtask

  initial begin
    bus.OPCODE = NOP; bus.C_FLAG = 0; bus.Z_FLAG = 0; bus.INT = 0;
    cyc(1, NOP, 0, 0, 0, E_INIT, 0, "rst_hold0");
    cyc(1, NOP, 0, 0, 0, E_INIT, 0, "rst_hold1");
    cyc(0, NOP, 0, 0, 0, E_INIT, 0, "rst_release");

    instr(BREQ, 0, 1, 0, 0, E_BR,   0, "breq_z1");
    instr(BREQ, 0, 0, 0, 0, E_NONE, 0, "breq_z0");
    instr(BRNE, 0, 0, 0, 0, E_BR,   0, "brne_z0");
    instr(BRNE, 0, 1, 0, 0, E_NONE, 0, "brne_z1");
    instr(BRCS, 1, 0, 0, 0, E_BR,   0, "brcs_c1");
    instr(BRCS, 0, 0, 0, 0, E_NONE, 0, "brcs_c0");
    instr(BRCC, 0, 0, 0, 0, E_BR,   0, "brcc_c0");
    instr(BRCC, 1, 0, 0, 0, E_NONE, 0, "brcc_c1");
    instr(BRN,  0, 0, 0, 0, E_BR,   0, "brn");
    instr(CALL, 0, 0, 0, 0, E_CALL, 0, "call");
    instr(RET,  0, 0, 0, 0, E_RET,  0, "ret");
    instr(NOP,  1, 1, 0, 0, E_NONE, 0, "other_op");

    // Interrupt while disabled stays pending through NOP and CLI
    instr(NOP, 0, 0, 1, 0, E_NONE, 0, "int_masked");
    instr(CLI, 0, 0, 0, 0, E_NONE, 0, "cli_masked");
    instr(SEI, 0, 0, 0, 0, E_NONE, 0, "sei_take");
    cyc(0, NOP, 0, 0, 0, E_INTR, 1, "intr_after_sei");
    instr(NOP, 0, 0, 0, 0, E_NONE, 0, "post_intr");

    // RETID / RETIE
    instr(SEI,   0, 0, 0, 0, E_NONE, 0, "sei");
    instr(RETID, 0, 0, 0, 0, E_RETI, 1, "retid");
    instr(NOP,   0, 0, 0, 0, E_NONE, 0, "after_retid");
    instr(RETIE, 0, 0, 0, 0, E_RETI, 0, "retie");

    // INT during CALL: CALL push, then INTR push
    instr(CALL, 0, 0, 0, 1, E_CALL, 1, "call_int");
    cyc(0, NOP, 0, 0, 0, E_INTR, 1, "intr_after_call");
    instr(NOP, 0, 0, 0, 0, E_NONE, 0, "post_call_intr");

    // CLI with a request in the same EXEC: no INTR, stays pending
    instr(SEI, 0, 0, 0, 0, E_NONE, 0, "sei_b");
    instr(CLI, 0, 0, 0, 1, E_NONE, 1, "cli_int");
    instr(NOP, 0, 0, 0, 0, E_NONE, 0, "cli_hold");

    // SEI releases it; reset lands inside the INTR cycle
    instr(SEI, 0, 0, 0, 0, E_NONE, 0, "sei_c");
    cyc(1, NOP, 0, 0, 0, E_INIT, 0, "rst_mid_intr");
    cyc(1, NOP, 0, 0, 0, E_INIT, 0, "rst_hold2");
    cyc(0, NOP, 0, 0, 0, E_INIT, 0, "rst_release2");

    // Pending cleared by reset: SEI must not raise INTR
    instr(SEI, 0, 0, 0, 0, E_NONE, 0, "sei_nopend");
    instr(NOP, 0, 0, 0, 0, E_NONE, 1, "no_stale_int");

    @(posedge CLK);
    repeat (4) begin
      if (exp_q.size() != 0) @(negedge CLK);
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
